stack_mem_ctrl: RTL and testbench
=================================

# stack_mem_ctrl

Sequencer that owns the data-memory port for the CPU's load/store and stack instructions. It latches one command per request, resolves its effective address (register-indirect ALU result, stack pointer, or absolute address), drives a request/acknowledge handshake to data memory, and maintains the hardware stack pointer. It sits between the decode/execute stage and data memory and replaces free-running combinational address selection with a controlled, one-access-at-a-time sequence that checks for stack overflow and underflow.

## Interface
- `ADDR_W`, 16, address and data width
- `STACK_TOP`, 16'h0800, SP reset value and empty point (stack grows downward)
- `STACK_LIMIT`, 16'h0700, lowest legal SP; SP == limit means full (256 entries)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  command strobe, sampled only in IDLE
- `PUSH`, `POP`  in  1 each  stack operation select
- `reg_addr`  in  1  use `alu_result` as address
- `we`  in  1  store (1) / load (0); ignored for PUSH/POP
- `addr`  in  ADDR_W  absolute address
- `alu_result`  in  ADDR_W  register-indirect address
- `wdata`  in  ADDR_W  store/push data
- `mem_req`  out  1  memory request, held until ack
- `mem_we`  out  1  write enable, qualified by mem_req
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  ADDR_W  memory write data
- `mem_rdata`  in  ADDR_W  memory read data, valid with mem_ack
- `mem_ack`  in  1  memory completion, one cycle
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with done: overflow, underflow or illegal command
- `rdata`  out  ADDR_W  load/pop result, held until the next load/pop completes
- `sp`  out  ADDR_W  current stack pointer

## Operation
- States: IDLE, REQ, DONE.
- IDLE: on `start`, latch all command inputs. Select the address by priority: `reg_addr` -> `alu_result`; else PUSH -> `sp-1`; else POP -> `sp`; else `addr`.
- Illegal commands (`PUSH && POP`, `reg_addr` with PUSH or POP), PUSH with `sp == STACK_LIMIT`, and POP with `sp == STACK_TOP` go directly to DONE with `err=1`. They issue no memory request and leave `sp` unchanged.
- All other commands go to REQ.
- REQ: `mem_req=1`. `mem_addr`, `mem_we` and `mem_wdata` stay stable from the latched command. PUSH forces `mem_we=1`; POP forces `mem_we=0`.
- On `mem_ack`:
  - capture `mem_rdata` into `rdata` on a read;
  - PUSH: `sp <= sp-1`;
  - POP: `sp <= sp+1`;
  - go to DONE.
- DONE: `done=1` for one cycle, then return to IDLE. `start` during REQ or DONE is ignored and is not queued.
- `sp` arithmetic is ADDR_W-bit unsigned. Wrap is impossible because of the limit checks.

## Timing
- Reset values: `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `busy=0`, `done=0`, `err=0`, `rdata=0`, `sp=STACK_TOP`; state IDLE.
- `start` sampled at edge N: `mem_req` is high after N. With `mem_ack` at edge N+1, `done` is high during cycle N+2. Minimum latency is 2 cycles from the start edge to `done`.
- Error path: `done`/`err` are high during cycle N+1.
- `mem_ack` outside REQ is ignored.
- Asserting `rst_n` low mid-access drops `mem_req` immediately. The in-flight command is abandoned, `sp` returns to `STACK_TOP`, and no `done` is produced.
- Back-to-back: the next `start` is accepted in the IDLE cycle after DONE, giving one command per 3 cycles at best.

## Structure
- The shared CPU package holds the state encoding (IDLE/REQ/DONE) and the default `STACK_TOP`/`STACK_LIMIT` constants.
- The stack pointer register and its full/empty compare form a sub-module, `stack_ptr`, with inc/dec enables and `full`/`empty` flags. The FSM and address latch stay in the top module.

## Test plan
- After reset: `sp=16'h0800`, all outputs 0. Assert `start` with PUSH and `wdata=16'h1234`, ack after 3 wait cycles -> `mem_addr=16'h07FF`, `mem_we=1`, `mem_req` held 4 cycles; then one `done` with `err=0`, `sp=16'h07FF`.
- POP immediately after that push, `mem_rdata=16'h1234` with ack -> `mem_addr=16'h07FF`, `mem_we=0`, `rdata=16'h1234`, `sp=16'h0800`.
- POP at `sp=16'h0800` -> no `mem_req`, `done` and `err` high the cycle after start, `sp` unchanged. 256 pushes, then a 257th -> `err=1`, `sp=16'h0700`.
- Load with `reg_addr=1`, `alu_result=16'h0042`, `addr=16'h0099`, PUSH=0 -> `mem_addr=16'h0042`. Store with `reg_addr=0`, `we=1`, `addr=16'h0099` -> `mem_addr=16'h0099`, `mem_we=1`.
- Illegal `start` with PUSH=POP=1 -> `err=1`, no request. `start` pulses during REQ are ignored, so exactly one `done` is produced per accepted command.
- Drive `rst_n` low while REQ waits for ack after two pushes -> `mem_req` falls asynchronously, `sp=16'h0800`, no `done`. A new command is accepted after reset release.

Source files
------------

// File: rtl/stack_mem_ctrl_pkg.sv
// Shared definitions for the load/store/stack memory sequencer:
// FSM state encoding and default stack geometry.
package stack_mem_ctrl_pkg;

   localparam int          ADDR_W_DEF      = 16;
   localparam logic [15:0] STACK_TOP_DEF   = 16'h0800;  // SP reset value, empty point
   localparam logic [15:0] STACK_LIMIT_DEF = 16'h0700;  // lowest legal SP, full point

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/stack_mem_ctrl_if.sv
// Data-memory port. Handshake: the master raises mem_req together with
// mem_we/mem_addr/mem_wdata and holds all of them stable until the slave
// returns a single-cycle mem_ack; mem_rdata is only meaningful in that
// ack cycle, and mem_we is only meaningful while mem_req is high.
interface stack_mem_ctrl_if #(
   parameter int ADDR_W = 16
) ();
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [ADDR_W-1:0] mem_wdata;
   logic [ADDR_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/stack_mem_ctrl_stack_ptr.sv
// Hardware stack pointer for a downward-growing stack, with full/empty
// flags used by the sequencer to reject overflowing pushes and
// underflowing pops before any memory access is issued.
module stack_mem_ctrl_stack_ptr
   import stack_mem_ctrl_pkg::*;
#(
   parameter int                ADDR_W      = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] STACK_TOP   = STACK_TOP_DEF,
   parameter logic [ADDR_W-1:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc,    // pop completed
   input  logic              dec,    // push completed
   output logic [ADDR_W-1:0] sp,
   output logic              full,
   output logic              empty
);

   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   // SP register; inc and dec are never both set by the sequencer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   sp <= STACK_TOP;
      else if (inc) sp <= sp + ONE;
      else if (dec) sp <= sp - ONE;
   end

   assign full  = (sp == STACK_LIMIT);
   assign empty = (sp == STACK_TOP);

endmodule

// File: rtl/stack_mem_ctrl.sv
// One-access-at-a-time sequencer for load/store/push/pop. Latches a
// command in IDLE, resolves its address, runs one req/ack transfer and
// reports completion (with err for rejected commands) via done.
module stack_mem_ctrl
   import stack_mem_ctrl_pkg::*;
#(
   parameter int                ADDR_W      = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] STACK_TOP   = STACK_TOP_DEF,
   parameter logic [ADDR_W-1:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              PUSH,
   input  logic              POP,
   input  logic              reg_addr,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] alu_result,
   input  logic [ADDR_W-1:0] wdata,
   stack_mem_ctrl_if.master  mem,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] rdata,
   output logic [ADDR_W-1:0] sp,
   output state_e            state_dbg
);

   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic              push_q, pop_q, we_q, err_q;
   logic [ADDR_W-1:0] addr_q, wdata_q;
   logic              sp_full, sp_empty, sp_inc, sp_dec;
   logic              cmd_illegal, cmd_err, xfer_done;
   logic [ADDR_W-1:0] sel_addr;

   stack_mem_ctrl_stack_ptr #(
      .ADDR_W      (ADDR_W),
      .STACK_TOP   (STACK_TOP),
      .STACK_LIMIT (STACK_LIMIT)
   ) u_stack_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (sp_inc),
      .dec   (sp_dec),
      .sp    (sp),
      .full  (sp_full),
      .empty (sp_empty)
   );

   // Command decode: address priority and rejection of illegal/over/underflow commands
   always_comb begin
      cmd_illegal = (PUSH && POP) || (reg_addr && (PUSH || POP));
      cmd_err     = cmd_illegal || (PUSH && sp_full) || (POP && sp_empty);
      if (reg_addr)  sel_addr = alu_result;
      else if (PUSH) sel_addr = sp - ONE;
      else if (POP)  sel_addr = sp;
      else           sel_addr = addr;
   end

   assign xfer_done = (state_q == S_REQ) && mem.mem_ack;
   assign sp_dec    = xfer_done && push_q;
   assign sp_inc    = xfer_done && pop_q;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state: rejected commands skip the memory access entirely
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = cmd_err ? S_DONE : S_REQ;
         S_REQ:   if (mem.mem_ack) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Command latch and read-data capture; starts outside IDLE are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         push_q  <= 1'b0;
         pop_q   <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata   <= '0;
      end else begin
         if (state_q == S_IDLE && start) begin
            push_q  <= PUSH;
            pop_q   <= POP;
            we_q    <= PUSH ? 1'b1 : (POP ? 1'b0 : we);
            err_q   <= cmd_err;
            addr_q  <= sel_addr;
            wdata_q <= wdata;
         end
         if (xfer_done && !we_q) rdata <= mem.mem_rdata;
      end
   end

   assign mem.mem_req   = (state_q == S_REQ);
   assign mem.mem_we    = (state_q == S_REQ) && we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign err           = (state_q == S_DONE) && err_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Directed bench for stack_mem_ctrl: a vector table of single commands
// plus hand-written sequences for ack outside REQ, start during REQ,
// stack overflow after 256 pushes, and reset in the middle of an access.
module tb_stack_mem_ctrl;
   import stack_mem_ctrl_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start, push, pop, reg_addr, we;
   logic [15:0] addr, alu_result, wdata;
   logic        busy, done, err;
   logic [15:0] rdata, sp;
   state_e      state_dbg;

   int n_vec = 0;
   int n_err = 0;

   stack_mem_ctrl_if #(.ADDR_W(16)) mem_bus ();

   stack_mem_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .PUSH       (push),
      .POP        (pop),
      .reg_addr   (reg_addr),
      .we         (we),
      .addr       (addr),
      .alu_result (alu_result),
      .wdata      (wdata),
      .mem        (mem_bus.master),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .rdata      (rdata),
      .sp         (sp),
      .state_dbg  (state_dbg)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        push, pop, reg_addr, we;
      logic [15:0] addr, alu, wdata, resp;
      int          wait_cyc;
      logic        exp_err;
      logic [15:0] exp_addr;
      logic        exp_we;
      logic [15:0] exp_rdata, exp_sp;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_cmd(input vec_t v);
      push       = v.push;
      pop        = v.pop;
      reg_addr   = v.reg_addr;
      we         = v.we;
      addr       = v.addr;
      alu_result = v.alu;
      wdata      = v.wdata;
   endtask

   // Runs one command from an IDLE negedge through its return to IDLE.
   task automatic run_vec(input vec_t v, input string tag);
      int req_cycles;
      set_cmd(v);
      start = 1'b1;
      tick();
      start = 1'b0;
      if (v.exp_err) begin
         check({tag, " done"}, 16'(done), 16'd1);
         check({tag, " err"}, 16'(err), 16'd1);
         check({tag, " req"}, 16'(mem_bus.mem_req), 16'd0);
         check({tag, " sp"}, sp, v.exp_sp);
         tick();
         check({tag, " done_clr"}, 16'(done), 16'd0);
         check({tag, " busy_clr"}, 16'(busy), 16'd0);
         check({tag, " rdata"}, rdata, v.exp_rdata);
      end else begin
         req_cycles = 0;
         if (mem_bus.mem_req) req_cycles++;
         check({tag, " addr"}, mem_bus.mem_addr, v.exp_addr);
         check({tag, " we"}, 16'(mem_bus.mem_we), 16'(v.exp_we));
         if (v.exp_we) check({tag, " wdata"}, mem_bus.mem_wdata, v.wdata);
         for (int i = 0; i < v.wait_cyc; i++) begin
            tick();
            if (mem_bus.mem_req) req_cycles++;
            check({tag, " early_done"}, 16'(done), 16'd0);
         end
         check({tag, " req_cycles"}, 16'(req_cycles), 16'(v.wait_cyc + 1));
         mem_bus.mem_ack   = 1'b1;
         mem_bus.mem_rdata = v.resp;
         tick();
         mem_bus.mem_ack   = 1'b0;
         mem_bus.mem_rdata = 16'h0;
         check({tag, " done"}, 16'(done), 16'd1);
         check({tag, " err"}, 16'(err), 16'd0);
         check({tag, " req_drop"}, 16'(mem_bus.mem_req), 16'd0);
         check({tag, " rdata"}, rdata, v.exp_rdata);
         check({tag, " sp"}, sp, v.exp_sp);
         tick();
         check({tag, " done_clr"}, 16'(done), 16'd0);
         check({tag, " busy_clr"}, 16'(busy), 16'd0);
      end
   endtask

   function automatic vec_t push_vec(input logic [15:0] d, input logic [15:0] exp_sp,
                                     input logic [15:0] exp_rd);
      vec_t v;
      v = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, d, 16'h0, 0,
            1'b0, exp_sp, 1'b1, exp_rd, exp_sp};
      return v;
   endfunction

   initial begin
      int   dones;
      vec_t v;

      // push pop rega we  addr     alu      wdata    resp    wait  err  exp_addr exp_we exp_rdata exp_sp
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 3, 1'b0, 16'h07FF, 1'b1, 16'h0000, 16'h07FF};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 0, 1'b0, 16'h07FF, 1'b0, 16'h1234, 16'h0800};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1'b1, 16'h0000, 1'b0, 16'h1234, 16'h0800};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0099, 16'h0042, 16'h0000, 16'hBEEF, 1, 1'b0, 16'h0042, 1'b0, 16'hBEEF, 16'h0800};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0099, 16'h0042, 16'h5555, 16'h0000, 2, 1'b0, 16'h0099, 1'b1, 16'hBEEF, 16'h0800};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1'b1, 16'h0000, 1'b0, 16'hBEEF, 16'h0800};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0300, 16'h0000, 16'h0000, 0, 1'b1, 16'h0000, 1'b0, 16'hBEEF, 16'h0800};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000, 0, 1'b0, 16'h07FF, 1'b1, 16'hBEEF, 16'h07FF};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0123, 16'h0000, 16'h0000, 16'h7777, 1, 1'b0, 16'h0123, 1'b0, 16'h7777, 16'h07FF};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hA5A5, 2, 1'b0, 16'h07FF, 1'b0, 16'hA5A5, 16'h0800};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1'b1, 16'h0000, 1'b0, 16'hA5A5, 16'h0800};

      // reset
      rst_n = 1'b0; start = 1'b0; push = 1'b0; pop = 1'b0; reg_addr = 1'b0; we = 1'b0;
      addr = 16'h0; alu_result = 16'h0; wdata = 16'h0;
      mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 16'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst sp", sp, 16'h0800);
      check("rst req", 16'(mem_bus.mem_req), 16'd0);
      check("rst we", 16'(mem_bus.mem_we), 16'd0);
      check("rst addr", mem_bus.mem_addr, 16'h0);
      check("rst wdata", mem_bus.mem_wdata, 16'h0);
      check("rst busy", 16'(busy), 16'd0);
      check("rst done", 16'(done), 16'd0);
      check("rst err", 16'(err), 16'd0);
      check("rst rdata", rdata, 16'h0);

      // vector table
      for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // ack while IDLE must do nothing
      mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'hDEAD;
      tick();
      mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 16'h0;
      check("idle_ack busy", 16'(busy), 16'd0);
      check("idle_ack done", 16'(done), 16'd0);
      check("idle_ack rdata", rdata, 16'hA5A5);
      check("idle_ack sp", sp, 16'h0800);

      // start held/pulsed during REQ and DONE: exactly one completion
      v = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0, 16'h0, 16'h3C3C, 0,
            1'b0, 16'h0200, 1'b0, 16'h3C3C, 16'h0800};
      set_cmd(v);
      dones = 0;
      start = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         start = (i % 2 == 0);
         addr  = 16'h0333;
         tick();
         if (done) dones++;
      end
      check("busy_start addr", mem_bus.mem_addr, 16'h0200);
      start = 1'b1;
      mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h3C3C;
      tick();
      mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 16'h0;
      if (done) dones++;
      tick();
      start = 1'b0;
      if (done) dones++;
      check("busy_start idle", 16'(busy), 16'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done) dones++;
      end
      check("busy_start dones", 16'(dones), 16'd1);
      check("busy_start rdata", rdata, 16'h3C3C);

      // 256 pushes fill the stack, the 257th overflows
      for (int i = 0; i < 256; i++)
         run_vec(push_vec(16'(i), 16'(16'h0800 - 16'(i + 1)), 16'h3C3C), $sformatf("fill%0d", i));
      check("full sp", sp, 16'h0700);
      v = push_vec(16'hFFFF, 16'h0700, 16'h3C3C);
      v.exp_err = 1'b1;
      run_vec(v, "overflow");

      // reset in the middle of a pending access
      rst_n = 1'b0;
      #1;
      check("rst2 sp", sp, 16'h0800);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec(push_vec(16'h1111, 16'h07FF, 16'h0000), "pre1");
      run_vec(push_vec(16'h2222, 16'h07FE, 16'h0000), "pre2");
      set_cmd(push_vec(16'h3333, 16'h07FD, 16'h0000));
      start = 1'b1;
      tick();
      start = 1'b0;
      check("mid req", 16'(mem_bus.mem_req), 16'd1);
      check("mid addr", mem_bus.mem_addr, 16'h07FD);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid req_drop", 16'(mem_bus.mem_req), 16'd0);
      check("mid sp", sp, 16'h0800);
      check("mid busy", 16'(busy), 16'd0);
      dones = 0;
      mem_bus.mem_ack = 1'b1;
      @(negedge clk);
      mem_bus.mem_ack = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done) dones++;
      end
      check("mid dones", 16'(dones), 16'd0);
      check("mid sp_hold", sp, 16'h0800);
      run_vec(push_vec(16'h4444, 16'h07FF, 16'h0000), "post");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
